// File: rtl/div_unit.sv
// Multicycle restoring divider for DIV/DIVU: quotient -> lo_out, remainder -> hi_out.
// One quotient bit per clock; signs are stripped on entry and reapplied in FIX.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic             div_unsig,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_busy,
   output logic             div_done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_dvs;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_zero;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_quot_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_a_neg = ~div_unsig & dividend[WIDTH-1];
   assign w_b_neg = ~div_unsig & divisor[WIDTH-1];
   assign w_a_mag = w_a_neg ? -dividend : dividend;
   assign w_b_mag = w_b_neg ? -divisor  : divisor;

   // The compare uses the full WIDTH+1 shifted value; the difference is always < divisor,
   // so its low WIDTH bits are exact.
   assign w_shift = {r_acc, r_q[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dvs});
   assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

   assign w_quot_fix = (r_sign_a ^ r_sign_b) ? -r_q : r_q;
   assign w_rem_fix  = r_sign_a ? -r_acc : r_acc;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      div_busy = 1'b0;
      div_done = 1'b0;
      div_zero = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (div_start) w_next = (divisor == '0) ? S_DONE : S_CALC;
         end
         S_CALC: begin
            div_busy = 1'b1;
            if (r_cnt == CW'(1)) w_next = S_FIX;
         end
         S_FIX: begin
            div_busy = 1'b1;
            w_next   = S_DONE;
         end
         S_DONE: begin
            div_done = 1'b1;
            div_zero = r_zero;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_dvs    <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_zero   <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_start) begin
                  r_zero <= (divisor == '0);
                  if (divisor != '0) begin
                     r_acc    <= '0;
                     r_q      <= w_a_mag;
                     r_dvs    <= w_b_mag;
                     r_sign_a <= w_a_neg;
                     r_sign_b <= w_b_neg;
                     r_cnt    <= CW'(WIDTH);
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
               r_q   <= {r_q[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - CW'(1);
            end
            S_FIX: begin
               hi_out <= w_rem_fix;
               lo_out <= w_quot_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random DIV/DIVU traffic
// checked against a 64-bit arithmetic reference through an expected-result queue.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        div_start;
   logic        div_unsig;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_busy;
   logic        div_done;
   logic        div_zero;

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .div_start (div_start),
      .div_unsig (div_unsig),
      .dividend  (dividend),
      .divisor   (divisor),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .div_busy  (div_busy),
      .div_done  (div_done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // Expected entry: {zero_flag, hi, lo}
   logic [64:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit signed arithmetic, truncated back to 32 bits.
   task automatic ref_div(input logic u, input logic [31:0] a, input logic [31:0] b,
                          output logic [64:0] res);
      longint sa, sb, q, r;
      if (b == 32'd0) begin
         res = {1'b1, m_hi, m_lo};
      end else begin
         if (u) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end
         q    = sa / sb;
         r    = sa % sb;
         m_lo = q[31:0];
         m_hi = r[31:0];
         res  = {1'b0, m_hi, m_lo};
      end
   endtask

   always @(negedge clk) begin
      logic [64:0] e;
      if (reset === 1'b1 && div_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no result", hi_out, lo_out);
         end else begin
            e = exp_q.pop_front();
            check("hi", hi_out, e[63:32]);
            check("lo", lo_out, e[31:0]);
            check("zero", {31'd0, div_zero}, {31'd0, e[64]});
         end
      end
   end

   task automatic start_op(input logic u, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] e;
      @(negedge clk);
      div_start = 1'b1;
      div_unsig = u;
      dividend  = a;
      divisor   = b;
      ref_div(u, a, b, e);
      exp_q.push_back(e);
      @(negedge clk);
      div_start = 1'b0;
      div_unsig = 1'($urandom_range(0, 1));
      dividend  = $urandom;
      divisor   = $urandom;
   endtask

   // Called one negedge after the start edge; cyc counts cycles from start to done.
   task automatic wait_done(output int cyc, output int busy);
      cyc  = 1;
      busy = 0;
      while (div_done !== 1'b1 && cyc < 100) begin
         if (div_busy === 1'b1) busy++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_op(input logic u, input logic [31:0] a, input logic [31:0] b);
      int c, bz;
      start_op(u, a, b);
      wait_done(c, bz);
      check("latency", c, (b == 32'd0) ? 32'd1 : 32'd34);
      check("busy_cycles", bz, (b == 32'd0) ? 32'd0 : 32'd33);
   endtask

   initial begin
      int c, bz, ndone;
      logic        u;
      logic [31:0] a, b;
      reset     = 1'b0;
      div_start = 1'b0;
      div_unsig = 1'b0;
      dividend  = '0;
      divisor   = '0;
      m_hi      = '0;
      m_lo      = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", hi_out, 32'd0);
      check("rst_lo", lo_out, 32'd0);
      check("rst_busy", {31'd0, div_busy}, 32'd0);
      check("rst_done", {31'd0, div_done}, 32'd0);
      check("rst_zero", {31'd0, div_zero}, 32'd0);
      reset = 1'b1;

      run_op(1'b0, 32'd100, 32'd7);
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b0, 32'd7, 32'hFFFF_FFFE);
      run_op(1'b1, 32'hFFFF_FFFF, 32'd2);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

      // Divide by zero must leave the previous 100/7 result in place.
      run_op(1'b0, 32'd100, 32'd7);
      run_op(1'b0, 32'd12345, 32'd0);

      // A start pulse mid-calculation is ignored.
      start_op(1'b0, 32'd100, 32'd7);
      repeat (8) @(negedge clk);
      div_start = 1'b1;
      dividend  = 32'd9;
      divisor   = 32'd3;
      @(negedge clk);
      div_start = 1'b0;
      wait_done(c, bz);
      check("ignored_start_done", {31'd0, c < 100}, 32'd1);

      // Reset mid-calculation aborts with no done pulse.
      start_op(1'b0, 32'd100, 32'd7);
      repeat (13) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_q.delete();
      m_hi  = '0;
      m_lo  = '0;
      reset = 1'b1;
      check("midrst_hi", hi_out, 32'd0);
      check("midrst_lo", lo_out, 32'd0);
      check("midrst_busy", {31'd0, div_busy}, 32'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (div_done === 1'b1) ndone++;
      end
      check("midrst_no_done", ndone, 32'd0);
      run_op(1'b0, 32'd9, 32'd3);

      for (int i = 0; i < 60; i++) begin
         u = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       a = $urandom_range(0, 50);
            1:       a = -$urandom_range(0, 50);
            2:       a = 32'h8000_0000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = $urandom_range(1, 20);
            4:       b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         run_op(u, a, b);
      end

      @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
